// File: rtl/pixel_stream_sink.sv
// Pixel stream sink: packs raster pixels into a frame-buffer write port and
// scans the buffer out as 800x600 VGA. Optional macro PIX_BORDER_EN adds a white frame.
module pixel_stream_sink #(
    parameter int IMG_ROW = 540,
    parameter int IMG_COL = 540,
    parameter int H_ACT   = 800,
    parameter int H_FP    = 40,
    parameter int H_SYNC  = 128,
    parameter int H_BP    = 88,
    parameter int V_ACT   = 600,
    parameter int V_FP    = 1,
    parameter int V_SYNC  = 4,
    parameter int V_BP    = 23
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  pixel_i,
    input  logic        pixel_en_i,
    input  logic        frame_clr_i,
    output logic        wr_en_o,
    output logic [18:0] wr_addr_o,
    output logic [7:0]  wr_data_o,
    output logic [18:0] rd_addr_o,
    input  logic [7:0]  rd_data_i,
    output logic [3:0]  vga_r_o,
    output logic [3:0]  vga_g_o,
    output logic [3:0]  vga_b_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        frame_done_o,
    output logic [9:0]  cnt_row_o,
    output logic        drop_o
);

    // state | meaning
    // IDLE  | waiting for the first pixel of a frame
    // RECV  | storing pixels in raster order
    // DONE  | full frame stored, further pixels dropped
    typedef enum logic [1:0] {IDLE, RECV, DONE} wr_state_t;

    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOT - 1);
    localparam logic [10:0] H_IMG    = 11'(IMG_COL);
    localparam logic [10:0] H_ACT_L  = 11'(H_ACT);
    localparam logic [10:0] H_SYNC_S = 11'(H_ACT + H_FP);
    localparam logic [10:0] H_SYNC_E = 11'(H_ACT + H_FP + H_SYNC - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0]  V_IMG    = 10'(IMG_ROW);
    localparam logic [9:0]  V_ACT_L  = 10'(V_ACT);
    localparam logic [9:0]  V_SYNC_S = 10'(V_ACT + V_FP);
    localparam logic [9:0]  V_SYNC_E = 10'(V_ACT + V_FP + V_SYNC - 1);
    localparam logic [9:0]  COL_LAST = 10'(IMG_COL - 1);
    localparam logic [9:0]  ROW_LAST = 10'(IMG_ROW - 1);

    wr_state_t   state_q, state_d;
    logic [9:0]  col_q, row_q;
    logic [18:0] addr_q;
    logic        accept, clear, last_pix;
    logic        wr_en_q, drop_q;
    logic [18:0] wr_addr_q;
    logic [7:0]  wr_data_q;

    assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pixel_en_i) begin
                    accept  = 1'b1;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (frame_clr_i) begin
                    clear   = 1'b1;
                    state_d = IDLE;
                end else if (pixel_en_i) begin
                    accept = 1'b1;
                    if (last_pix) state_d = DONE;
                end
            end
            DONE: begin
                if (frame_clr_i) begin
                    clear   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // The last pixel leaves row/col parked on the final position, which gives
    // the saturated row readout in DONE for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else if (clear) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else if (accept && !last_pix) begin
            addr_q <= addr_q + 19'd1;
            if (col_q == COL_LAST) begin
                col_q <= '0;
                row_q <= row_q + 10'd1;
            end else begin
                col_q <= col_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            wr_en_q <= accept;
            drop_q  <= pixel_en_i && !accept;
            if (accept) begin
                wr_addr_q <= addr_q;
                wr_data_q <= pixel_i;
            end
        end
    end

    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign drop_o       = drop_q;
    assign frame_done_o = (state_q == DONE);
    assign cnt_row_o    = row_q;

    logic [10:0] h_q;
    logic [9:0]  v_q;
    logic        h_wrap, v_wrap, in_img, hs_raw, vs_raw;
    logic [18:0] rd_cnt_q, rd_addr_q;
    logic [2:0]  hs_pipe, vs_pipe;
    logic [1:0]  in_img_pipe;
    logic [3:0]  pix_q;
    logic        unused_rd_lsb;

    assign h_wrap        = (h_q == H_LAST);
    assign v_wrap        = (v_q == V_LAST);
    assign in_img        = (h_q < H_IMG) && (v_q < V_IMG);
    assign hs_raw        = (h_q >= H_SYNC_S) && (h_q <= H_SYNC_E);
    assign vs_raw        = (v_q >= V_SYNC_S) && (v_q <= V_SYNC_E);
    assign unused_rd_lsb = ^rd_data_i[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_wrap ? 11'd0 : h_q + 11'd1;
            if (h_wrap) v_q <= v_wrap ? 10'd0 : v_q + 10'd1;
        end
    end

    // rd_addr only follows the read counter inside the image, so it never
    // leaves the frame-buffer range during blanking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q  <= '0;
            rd_addr_q <= '0;
        end else begin
            if (h_wrap && v_wrap) rd_cnt_q <= '0;
            else if (in_img)      rd_cnt_q <= rd_cnt_q + 19'd1;
            if (in_img) rd_addr_q <= rd_cnt_q;
        end
    end

`ifdef PIX_BORDER_EN
    logic       border_raw;
    logic [1:0] border_pipe;

    assign border_raw = (h_q < H_ACT_L) && (v_q < V_ACT_L) && (h_q <= H_IMG) && (v_q <= V_IMG)
                        && ((h_q == H_IMG) || (v_q == V_IMG));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) border_pipe <= '0;
        else        border_pipe <= {border_pipe[0], border_raw};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_pipe     <= '0;
            vs_pipe     <= '0;
            in_img_pipe <= '0;
            pix_q       <= '0;
        end else begin
            hs_pipe     <= {hs_pipe[1:0], hs_raw};
            vs_pipe     <= {vs_pipe[1:0], vs_raw};
            in_img_pipe <= {in_img_pipe[0], in_img};
            if (in_img_pipe[1])
                pix_q <= rd_data_i[7:4];
`ifdef PIX_BORDER_EN
            else if (border_pipe[1])
                pix_q <= 4'hF;
`endif
            else
                pix_q <= 4'h0;
        end
    end

    assign rd_addr_o = rd_addr_q;
    assign vga_r_o   = pix_q;
    assign vga_g_o   = pix_q;
    assign vga_b_o   = pix_q;
    assign hsync_o   = hs_pipe[2];
    assign vsync_o   = vs_pipe[2];

endmodule

// File: tb/tb_pixel_stream_sink.sv
// Self-checking bench for pixel_stream_sink, run on a shrunken 8x6 image and
// 20x14 raster so full frames fit in a short simulation.
`timescale 1ns/1ps
module tb_pixel_stream_sink;

    localparam int IMG_ROW = 6, IMG_COL = 8;
    localparam int H_ACT = 12, H_FP = 2, H_SYNC = 3, H_BP = 3;
    localparam int V_ACT = 9, V_FP = 1, V_SYNC = 2, V_BP = 2;
    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int F_TOT = H_TOT * V_TOT;
    localparam int NPIX  = IMG_ROW * IMG_COL;

    logic        clk, rst_n;
    logic [7:0]  pixel_i;
    logic        pixel_en_i, frame_clr_i;
    logic        wr_en_o;
    logic [18:0] wr_addr_o, rd_addr_o;
    logic [7:0]  wr_data_o, rd_data_i;
    logic [3:0]  vga_r_o, vga_g_o, vga_b_o;
    logic        hsync_o, vsync_o, frame_done_o, drop_o;
    logic [9:0]  cnt_row_o;

    pixel_stream_sink #(
        .IMG_ROW(IMG_ROW), .IMG_COL(IMG_COL),
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pixel_i(pixel_i), .pixel_en_i(pixel_en_i),
        .frame_clr_i(frame_clr_i), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
        .wr_data_o(wr_data_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .vga_r_o(vga_r_o), .vga_g_o(vga_g_o), .vga_b_o(vga_b_o),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .frame_done_o(frame_done_o),
        .cnt_row_o(cnt_row_o), .drop_o(drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-buffer model: synchronous write, one-cycle read latency.
    logic [7:0] mem [0:63];
    logic       bram_const;
    always @(posedge clk) begin
        if (wr_en_o) mem[wr_addr_o[5:0]] <= wr_data_o;
        rd_data_i <= bram_const ? 8'hA5 : mem[rd_addr_o[5:0]];
    end

    // Raster index since reset release: after posedge k, cyc == k.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int hpos(input int j); return j % H_TOT; endfunction
    function automatic int vpos(input int j); return (j / H_TOT) % V_TOT; endfunction

    function automatic bit f_in_img(input int j);
        return (hpos(j) < IMG_COL) && (vpos(j) < IMG_ROW);
    endfunction

    // Read address expected after index j: last in-image address reached so far this frame.
    function automatic int f_last_addr(input int j);
        int h, v;
        h = hpos(j);
        v = vpos(j);
        if (v >= IMG_ROW) return NPIX - 1;
        if (h >= IMG_COL) return v * IMG_COL + IMG_COL - 1;
        return v * IMG_COL + h;
    endfunction

    function automatic bit f_hs(input int j);
        return (hpos(j) >= H_ACT + H_FP) && (hpos(j) < H_ACT + H_FP + H_SYNC);
    endfunction

    function automatic bit f_vs(input int j);
        return (vpos(j) >= V_ACT + V_FP) && (vpos(j) < V_ACT + V_FP + V_SYNC);
    endfunction

`ifdef PIX_BORDER_EN
    function automatic bit f_border(input int j);
        int h, v;
        h = hpos(j);
        v = vpos(j);
        return (h < H_ACT) && (v < V_ACT) && (h <= IMG_COL) && (v <= IMG_ROW)
               && ((h == IMG_COL) || (v == IMG_ROW));
    endfunction
`endif

    function automatic int exp_rgb(input int k, input bit cmode);
        int j;
        if (k < 3) return 0;
        j = k - 3;
        if (f_in_img(j)) begin
            if (cmode) return 10;
            return ((vpos(j) * IMG_COL + hpos(j)) & 255) >> 4;
        end
`ifdef PIX_BORDER_EN
        if (f_border(j)) return 15;
`endif
        return 0;
    endfunction

    typedef struct {
        logic       en;
        logic [7:0] pix;
        logic       clr;
        logic       exp_wr;
        int         exp_addr;
        int         exp_data;
        logic       exp_drop;
        logic       exp_done;
        int         exp_row;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic en, input int pix, input logic clr, input logic ew,
                           input int ea, input logic edr, input logic edn, input int er);
        vec_t v;
        v.en = en; v.pix = 8'(pix); v.clr = clr; v.exp_wr = ew; v.exp_addr = ea;
        v.exp_data = pix; v.exp_drop = edr; v.exp_done = edn; v.exp_row = er;
        vecs.push_back(v);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " wr_en"},   int'(wr_en_o), 0);
        chk({tag, " wr_addr"}, int'(wr_addr_o), 0);
        chk({tag, " wr_data"}, int'(wr_data_o), 0);
        chk({tag, " rd_addr"}, int'(rd_addr_o), 0);
        chk({tag, " rgb"},     int'({vga_r_o, vga_g_o, vga_b_o}), 0);
        chk({tag, " syncs"},   int'({hsync_o, vsync_o}), 0);
        chk({tag, " done"},    int'(frame_done_o), 0);
        chk({tag, " row"},     int'(cnt_row_o), 0);
        chk({tag, " drop"},    int'(drop_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int hs_rise, vs_rise, hs_prev, vs_prev, k, first_hs, first_vs;

        // Full frame back-to-back, 5 drops in DONE, clear, restart at 0.
        for (int i = 0; i < NPIX; i++)
            add_vec(1, i, 0, 1, i, 0, i == NPIX - 1, (i == NPIX - 1) ? IMG_ROW - 1 : (i + 1) / IMG_COL);
        for (int i = 0; i < 5; i++) add_vec(1, 8'hEE, 0, 0, 0, 1, 1, IMG_ROW - 1);
        add_vec(0, 0, 1, 0, 0, 0, 0, 0);
        add_vec(1, 8'h3C, 0, 1, 0, 0, 0, 0);
        // Pixels every 3rd clock; address must not skip, row reaches 2 after pixel 16.
        for (int p = 1; p <= 20; p++) begin
            add_vec(0, 0, 0, 0, 0, 0, 0, p / IMG_COL);
            add_vec(0, 0, 0, 0, 0, 0, 0, p / IMG_COL);
            add_vec(1, 8'h40 + p, 0, 1, p, 0, 0, (p + 1) / IMG_COL);
        end
        // Clear coincident with a pixel mid-RECV: pixel dropped, next write at 0.
        add_vec(1, 8'h99, 1, 0, 0, 1, 0, 0);
        add_vec(1, 8'h77, 0, 1, 0, 0, 0, 0);

        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        bram_const  = 1'b1;
        rst_n       = 1'b0;
        pixel_i     = '0;
        pixel_en_i  = 1'b0;
        frame_clr_i = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            pixel_en_i  = vecs[i].en;
            pixel_i     = vecs[i].pix;
            frame_clr_i = vecs[i].clr;
            @(negedge clk);
            chk($sformatf("vec%0d wr_en", i), int'(wr_en_o), int'(vecs[i].exp_wr));
            if (vecs[i].exp_wr) begin
                chk($sformatf("vec%0d wr_addr", i), int'(wr_addr_o), vecs[i].exp_addr);
                chk($sformatf("vec%0d wr_data", i), int'(wr_data_o), vecs[i].exp_data);
            end
            chk($sformatf("vec%0d drop", i), int'(drop_o), int'(vecs[i].exp_drop));
            chk($sformatf("vec%0d done", i), int'(frame_done_o), int'(vecs[i].exp_done));
            chk($sformatf("vec%0d row", i), int'(cnt_row_o), vecs[i].exp_row);
        end
        pixel_en_i  = 1'b0;
        frame_clr_i = 1'b0;

        // Clear out of RECV, then store a frame with pixel = address for the scan-out check.
        frame_clr_i = 1'b1;
        @(negedge clk);
        frame_clr_i = 1'b0;
        for (int a = 0; a < NPIX; a++) begin
            pixel_en_i = 1'b1;
            pixel_i    = 8'(a);
            @(negedge clk);
            chk("fill wr_en", int'(wr_en_o), 1);
            chk("fill wr_addr", int'(wr_addr_o), a);
        end
        pixel_en_i = 1'b0;
        @(negedge clk);
        chk("fill done", int'(frame_done_o), 1);
        chk("fill row", int'(cnt_row_o), IMG_ROW - 1);
        chk("fill wr_en idle", int'(wr_en_o), 0);

        // Scan-out: one frame with constant 0xA5 read data, then two from the stored frame.
        hs_rise = -1; vs_rise = -1; hs_prev = 0; vs_prev = 0;
        for (int i = 0; i < 3 * F_TOT; i++) begin
            if (i == F_TOT) bram_const = 1'b0;
            @(negedge clk);
            k = cyc;
            if (i < F_TOT || i > F_TOT + 4) begin
                chk("rgb r", int'(vga_r_o), exp_rgb(k, bram_const));
                chk("rgb g", int'(vga_g_o), exp_rgb(k, bram_const));
                chk("rgb b", int'(vga_b_o), exp_rgb(k, bram_const));
            end
            chk("hsync", int'(hsync_o), (k >= 3) ? int'(f_hs(k - 3)) : 0);
            chk("vsync", int'(vsync_o), (k >= 3) ? int'(f_vs(k - 3)) : 0);
            chk("rd_addr", int'(rd_addr_o), (k >= 1) ? f_last_addr(k - 1) : 0);
            if (hsync_o && !hs_prev) begin
                if (hs_rise >= 0) chk("hsync period", k - hs_rise, H_TOT);
                hs_rise = k;
            end
            if (!hsync_o && hs_prev && hs_rise >= 0) chk("hsync width", k - hs_rise, H_SYNC);
            if (vsync_o && !vs_prev) begin
                if (vs_rise >= 0) chk("vsync period", k - vs_rise, F_TOT);
                vs_rise = k;
            end
            if (!vsync_o && vs_prev && vs_rise >= 0) chk("vsync width", k - vs_rise, V_SYNC * H_TOT);
            hs_prev = int'(hsync_o);
            vs_prev = int'(vsync_o);
        end

        // Start a new frame, then reset mid-frame while RECV and inside the image.
        bram_const  = 1'b1;
        frame_clr_i = 1'b1;
        @(negedge clk);
        frame_clr_i = 1'b0;
        for (int a = 0; a < 10; a++) begin
            pixel_en_i = 1'b1;
            pixel_i    = 8'h30 + 8'(a);
            @(negedge clk);
        end
        pixel_en_i = 1'b0;
        for (int i = 0; i <= F_TOT && (cyc % F_TOT) != (IMG_ROW / 2 + 1) * H_TOT + 5; i++)
            @(negedge clk);
        chk("pre-reset rgb", int'(vga_r_o), exp_rgb(cyc, 1'b1));
        chk("pre-reset row", int'(cnt_row_o), 1);
        chk("pre-reset done", int'(frame_done_o), 0);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async reset");
        @(negedge clk);
        rst_n = 1'b1;

        first_hs = -1;
        first_vs = -1;
        pixel_en_i = 1'b1;
        pixel_i    = 8'h5A;
        @(negedge clk);
        pixel_en_i = 1'b0;
        chk("restart wr_addr", int'(wr_addr_o), 0);
        chk("restart wr_en", int'(wr_en_o), 1);
        chk("restart rd_addr", int'(rd_addr_o), 0);
        for (int i = 0; i < 2 * F_TOT && first_vs < 0; i++) begin
            if (hsync_o && first_hs < 0) first_hs = cyc;
            if (vsync_o && first_vs < 0) first_vs = cyc;
            if (first_vs < 0) @(negedge clk);
        end
        chk("first hsync index", first_hs, H_ACT + H_FP + 3);
        chk("first vsync index", first_vs, (V_ACT + V_FP) * H_TOT + 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
